// File: rtl/collision_scheduler.sv
// Purpose: time-share one bullet-bitmap collision scanner across NUM_INV invaders, round-robin.
// Latency: one bullet bit per clock; hit_valid pulses the cycle after the hitting bit is tested.
// Backpressure: none; enable gates scanning, and an explosion sweep always runs to completion.
module collision_scheduler #(
    parameter int          NUM_INV    = 4,
    parameter int          BULLET_W   = 119,
    parameter int          SCAN_LEN   = 117,
    parameter int          X_OFFSET   = 43,
    parameter int          HIT_OFFSET = 2,
    parameter int          FAST_TOL   = 2,
    parameter logic [24:0] ANIM_DIV   = 25'd25000000,
    parameter int          ANIM_STEP  = 2,
    parameter int          ANIM_END   = 159,
    localparam int         IDW        = (NUM_INV > 1) ? $clog2(NUM_INV) : 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [BULLET_W-1:0]   bullet_data,
    input  logic [8*NUM_INV-1:0]  inv_x,
    input  logic [NUM_INV-1:0]    inv_fast,
    input  logic [NUM_INV-1:0]    inv_alive,
    output logic                  hit_valid,
    output logic [IDW-1:0]        hit_id,
    output logic [7:0]            hit_x,
    output logic [7:0]            hit_k,
    output logic                  anim_active,
    output logic [7:0]            anim_coord,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_ANIM = 2'd2
    } state_t;

    localparam logic signed [9:0] FAST_TOL_S = 10'(FAST_TOL);

    state_t         state_q, state_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     k_q, k_d;
    logic [24:0]    tick_q, tick_d;
    logic           hit_valid_q, hit_valid_d;
    logic [IDW-1:0] hit_id_q, hit_id_d;
    logic [7:0]     hit_x_q, hit_x_d;
    logic [7:0]     hit_k_q, hit_k_d;
    logic           anim_active_q, anim_active_d;
    logic [7:0]     anim_coord_q, anim_coord_d;
    logic           busy_q, busy_d;

    // Per-invader and per-bit views of the live inputs for the current id / bit index
    logic [7:0]        cur_x;
    logic              cur_fast;
    logic              cur_alive;
    logic              cur_bit;
    logic [8:0]        sum_s;
    logic [8:0]        tgt_t;
    logic signed [9:0] diff;
    logic              hit;
    logic [IDW-1:0]    next_id;
    logic [8:0]        coord_sum;

    // Select the current invader's fields, the bullet bit under test, and evaluate the match
    always_comb begin
        cur_x     = 8'd0;
        cur_fast  = 1'b0;
        cur_alive = 1'b0;
        cur_bit   = 1'b0;
        for (int i = 0; i < NUM_INV; i++) begin
            if (id_q == IDW'(i)) begin
                cur_x     = inv_x[8*i +: 8];
                cur_fast  = inv_fast[i];
                cur_alive = inv_alive[i];
            end
        end
        for (int j = 0; j < BULLET_W; j++) begin
            if (k_q == 8'(j)) begin
                cur_bit = bullet_data[j];
            end
        end
        sum_s = {1'b0, k_q} + 9'(X_OFFSET);
        tgt_t = {1'b0, cur_x} + 9'(HIT_OFFSET);
        diff  = $signed({1'b0, tgt_t}) - $signed({1'b0, sum_s});
        // Fast invaders move between samples, so accept a small window ahead of the bullet
        if (cur_fast) begin
            hit = cur_bit && !diff[9] && (diff < FAST_TOL_S);
        end else begin
            hit = cur_bit && (sum_s == tgt_t);
        end
        next_id   = (id_q == IDW'(NUM_INV - 1)) ? '0 : id_q + IDW'(1);
        coord_sum = {1'b0, anim_coord_q} + 9'(ANIM_STEP);
    end

    // Next-state and output computation for the IDLE / SCAN / ANIM controller
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        k_d           = k_q;
        tick_d        = tick_q;
        hit_valid_d   = 1'b0;
        hit_id_d      = hit_id_q;
        hit_x_d       = hit_x_q;
        hit_k_d       = hit_k_q;
        anim_active_d = anim_active_q;
        anim_coord_d  = anim_coord_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SCAN;
                    id_d    = '0;
                    k_d     = 8'd0;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    id_d    = '0;
                    k_d     = 8'd0;
                end else if (!cur_alive) begin
                    // Dead invader costs exactly one cycle and no bit is tested
                    id_d = next_id;
                    k_d  = 8'd0;
                end else if (hit) begin
                    state_d       = ST_ANIM;
                    hit_valid_d   = 1'b1;
                    hit_id_d      = id_q;
                    hit_x_d       = cur_x;
                    hit_k_d       = k_q;
                    anim_coord_d  = (k_q == 8'd0) ? 8'd0 : k_q - 8'd1;
                    anim_active_d = 1'b1;
                    tick_d        = 25'd0;
                end else if (k_q == 8'(SCAN_LEN - 1)) begin
                    id_d = next_id;
                    k_d  = 8'd0;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            ST_ANIM: begin
                // enable is deliberately ignored here so a started sweep always finishes
                if (tick_q == ANIM_DIV - 25'd1) begin
                    tick_d = 25'd0;
                    if (coord_sum >= 9'(ANIM_END)) begin
                        anim_coord_d  = 8'd0;
                        anim_active_d = 1'b0;
                        id_d          = next_id;
                        k_d           = 8'd0;
                        state_d       = enable ? ST_SCAN : ST_IDLE;
                    end else begin
                        anim_coord_d = coord_sum[7:0];
                    end
                end else begin
                    tick_d = tick_q + 25'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                id_d    = '0;
                k_d     = 8'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            id_q          <= '0;
            k_q           <= 8'd0;
            tick_q        <= 25'd0;
            hit_valid_q   <= 1'b0;
            hit_id_q      <= '0;
            hit_x_q       <= 8'd0;
            hit_k_q       <= 8'd0;
            anim_active_q <= 1'b0;
            anim_coord_q  <= 8'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            k_q           <= k_d;
            tick_q        <= tick_d;
            hit_valid_q   <= hit_valid_d;
            hit_id_q      <= hit_id_d;
            hit_x_q       <= hit_x_d;
            hit_k_q       <= hit_k_d;
            anim_active_q <= anim_active_d;
            anim_coord_q  <= anim_coord_d;
            busy_q        <= busy_d;
        end
    end

    assign hit_valid   = hit_valid_q;
    assign hit_id      = hit_id_q;
    assign hit_x       = hit_x_q;
    assign hit_k       = hit_k_q;
    assign anim_active = anim_active_q;
    assign anim_coord  = anim_coord_q;
    assign busy        = busy_q;

endmodule
